// File: rtl/axis_playback_src_pkg.sv
// Shared types and defaults for the AXI-Stream playback source.
// Holds the FSM state encoding, the per-beat tag carried through the output buffer, and a width helper.
package axis_playback_src_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_FRAME_LEN = 64;
    localparam int DEF_FRAMES    = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } pb_state_e;

    // Side information travelling with each sample from read issue to the bus
    typedef struct packed {
        logic last;   // closes a frame
        logic fin;    // final sample of a non-looped playback
        logic wrap;   // final sample of a pass that continues at address 0
    } beat_tag_t;

    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_playback_src_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
// Contents carry no reset so loaded playback data survives rst.
module sdp_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= {WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/axis_playback_src.sv
// AXI-Stream playback source: streams a preloaded sample memory as FRAME_LEN-sample frames,
// optionally looping, through a 2-entry output buffer that tolerates downstream back-pressure.
module axis_playback_src
    import axis_playback_src_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int FRAMES    = DEF_FRAMES
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [$clog2(FRAMES*FRAME_LEN)-1:0]  wr_addr,
    input  logic [WIDTH-1:0]                     wr_data,
    input  logic                                 start,
    input  logic                                 loop,
    input  logic                                 abort,
    output logic [WIDTH-1:0]                     m_axis_tdata,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    output logic                                 busy,
    output logic                                 done,
    output logic [$clog2(FRAMES+1)-1:0]          frame_cnt,
    output logic                                 wr_err
);

    localparam int DEPTH = FRAMES * FRAME_LEN;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = width_of(FRAME_LEN);
    localparam int FCW   = $clog2(FRAMES + 1);

    pb_state_e        state_r, state_nx_s;
    logic [AW-1:0]    rd_addr_r;
    logic [PW-1:0]    pos_r;
    logic             rd_pending_r;
    beat_tag_t        rd_tag_r;
    logic [WIDTH-1:0] rd_data_s;
    logic [WIDTH-1:0] out_data_r, skid_data_r;
    beat_tag_t        out_tag_r, skid_tag_r;
    logic             out_valid_r, skid_valid_r;
    logic             busy_r, done_r, wr_err_r, clr_pend_r;
    logic [FCW-1:0]   frame_cnt_r;
    logic             start_ok_s, pop_s, rd_go_s, last_addr_s, wr_ok_s;
    logic [1:0]       occ_s;

    assign pop_s       = out_valid_r & m_axis_tready;
    assign start_ok_s  = (state_r == IDLE) & start & ~abort;
    assign last_addr_s = (rd_addr_r == AW'(DEPTH - 1));
    assign wr_ok_s     = wr_en & (state_r == IDLE);

    // Issue a read only if the buffer can still hold its data after this cycle's pop
    always_comb begin
        occ_s = 2'(out_valid_r) + 2'(skid_valid_r) + 2'(rd_pending_r) - 2'(pop_s);
        if (((state_r == PRIME) || (state_r == STREAM)) && !abort && (occ_s <= 2'd1)) begin
            rd_go_s = 1'b1;
        end else begin
            rd_go_s = 1'b0;
        end
    end

    // Next-state logic; abort overrides everything, including start
    always_comb begin
        state_nx_s = state_r;
        if (abort) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    if (start) state_nx_s = PRIME; else state_nx_s = IDLE;
                PRIME:   state_nx_s = STREAM;
                STREAM:  if (rd_go_s && last_addr_s && !loop) state_nx_s = DRAIN; else state_nx_s = STREAM;
                DRAIN:   if (pop_s && out_tag_r.fin) state_nx_s = IDLE; else state_nx_s = DRAIN;
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != IDLE);
        end
    end

    // Read address / frame position; loop is sampled as the pass's last address is read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_r    <= {AW{1'b0}};
            pos_r        <= {PW{1'b0}};
            rd_pending_r <= 1'b0;
            rd_tag_r     <= beat_tag_t'(3'b000);
        end else if (abort) begin
            rd_pending_r <= 1'b0;
            rd_tag_r     <= beat_tag_t'(3'b000);
        end else begin
            rd_pending_r <= rd_go_s;
            if (start_ok_s) begin
                rd_addr_r <= {AW{1'b0}};
                pos_r     <= {PW{1'b0}};
            end else if (rd_go_s) begin
                rd_tag_r.last <= (pos_r == PW'(FRAME_LEN - 1));
                rd_tag_r.fin  <= last_addr_s & ~loop;
                rd_tag_r.wrap <= last_addr_s & loop;
                rd_addr_r     <= last_addr_s ? {AW{1'b0}} : rd_addr_r + AW'(1);
                pos_r         <= (pos_r == PW'(FRAME_LEN - 1)) ? {PW{1'b0}} : pos_r + PW'(1);
            end
        end
    end

    sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok_s),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (rd_go_s),
        .raddr (rd_addr_r),
        .rdata (rd_data_s)
    );

    // Output buffer: head drives the bus, skid catches the read that lands during a stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r   <= {WIDTH{1'b0}};
            out_tag_r    <= beat_tag_t'(3'b000);
            out_valid_r  <= 1'b0;
            skid_data_r  <= {WIDTH{1'b0}};
            skid_tag_r   <= beat_tag_t'(3'b000);
            skid_valid_r <= 1'b0;
        end else if (abort) begin
            out_tag_r    <= beat_tag_t'(3'b000);
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (!out_valid_r || pop_s) begin
            if (skid_valid_r) begin
                out_data_r   <= skid_data_r;
                out_tag_r    <= skid_tag_r;
                out_valid_r  <= 1'b1;
                skid_data_r  <= rd_data_s;
                skid_tag_r   <= rd_tag_r;
                skid_valid_r <= rd_pending_r;
            end else if (rd_pending_r) begin
                out_data_r   <= rd_data_s;
                out_tag_r    <= rd_tag_r;
                out_valid_r  <= 1'b1;
            end else begin
                out_tag_r    <= beat_tag_t'(3'b000);
                out_valid_r  <= 1'b0;
            end
        end else if (rd_pending_r) begin
            skid_data_r  <= rd_data_s;
            skid_tag_r   <= rd_tag_r;
            skid_valid_r <= 1'b1;
        end
    end

    // Status: done/wr_err pulses and frame counter (a looped pass restarts the count at its first frame)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r      <= 1'b0;
            wr_err_r    <= 1'b0;
            frame_cnt_r <= {FCW{1'b0}};
            clr_pend_r  <= 1'b0;
        end else begin
            done_r   <= pop_s & out_tag_r.fin & ~abort;
            wr_err_r <= wr_en & (state_r != IDLE);
            if (start_ok_s) begin
                frame_cnt_r <= {FCW{1'b0}};
                clr_pend_r  <= 1'b0;
            end else if (pop_s && out_tag_r.last && !abort) begin
                if (clr_pend_r) begin
                    frame_cnt_r <= FCW'(1);
                end else if (frame_cnt_r != FCW'(FRAMES)) begin
                    frame_cnt_r <= frame_cnt_r + FCW'(1);
                end
                clr_pend_r <= out_tag_r.wrap;
            end
        end
    end

    assign m_axis_tdata  = out_data_r;
    assign m_axis_tvalid = out_valid_r;
    assign m_axis_tlast  = out_tag_r.last;
    assign busy          = busy_r;
    assign done          = done_r;
    assign frame_cnt     = frame_cnt_r;
    assign wr_err        = wr_err_r;

endmodule

// File: tb/tb_axis_playback_src.sv
// Self-checking bench for axis_playback_src with FRAME_LEN=8, FRAMES=2 (16-sample memory).
// Expected beats come from a memory image kept in the bench; frame counts from sample-index arithmetic.
module tb_axis_playback_src;

    localparam int WIDTH     = 32;
    localparam int FRAME_LEN = 8;
    localparam int FRAMES    = 2;
    localparam int DEPTH     = FRAME_LEN * FRAMES;
    localparam int AW        = $clog2(DEPTH);
    localparam int FCW       = $clog2(FRAMES + 1);

    logic             clk = 1'b0;
    logic             rst, wr_en, start, loop, abort, m_axis_tready;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data, m_axis_tdata;
    logic             m_axis_tvalid, m_axis_tlast, busy, done, wr_err;
    logic [FCW-1:0]   frame_cnt;

    logic [WIDTH-1:0] mem_m [DEPTH];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_playback_src #(
        .WIDTH     (WIDTH),
        .FRAME_LEN (FRAME_LEN),
        .FRAMES    (FRAMES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .start         (start),
        .loop          (loop),
        .abort         (abort),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done),
        .frame_cnt     (frame_cnt),
        .wr_err        (wr_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mem(input bit ramp);
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = ramp ? WIDTH'(i) : WIDTH'($urandom);
            mem_m[i] = wr_data;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; loop = 1'b0; abort = 1'b0; m_axis_tready = 1'b0;
        tick(); tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err got %b want 0", wr_err); end
        checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy got %b want 0", busy); end
    endtask

    // One full non-looped pass; mode 0: tready high, 1: pattern 1,0,0,1, 2: random tready
    task automatic test_replay(input string tag, input int mode);
        int got, cyc, exp_fc;
        bit stalled;
        logic [WIDTH-1:0] held_d;
        logic held_l, exp_l;
        loop = 1'b0; m_axis_tready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL %s_lat0 tvalid got %b want 0", tag, m_axis_tvalid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy got %b want 1", tag, busy); end
        checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL %s_fc_clear got %0d want 0", tag, frame_cnt); end
        tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL %s_lat1 tvalid got %b want 0", tag, m_axis_tvalid); end
        tick();
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== mem_m[0]) begin
            errors++; $display("FAIL %s_first got v=%b d=%h want v=1 d=%h", tag, m_axis_tvalid, m_axis_tdata, mem_m[0]); end
        got = 0; cyc = 0; exp_fc = 0; stalled = 1'b0; held_d = '0; held_l = 1'b0;
        while (got < DEPTH && cyc < 200) begin
            case (mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            start = (cyc == 3);
            if (stalled) begin
                checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held_d || m_axis_tlast !== held_l) begin
                    errors++; $display("FAIL %s_stall got v=%b d=%h l=%b want v=1 d=%h l=%b", tag, m_axis_tvalid, m_axis_tdata, m_axis_tlast, held_d, held_l); end
            end
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                exp_l = ((got % FRAME_LEN) == FRAME_LEN - 1);
                checks++; if (m_axis_tdata !== mem_m[got]) begin errors++; $display("FAIL %s_beat%0d tdata got %h want %h", tag, got, m_axis_tdata, mem_m[got]); end
                checks++; if (m_axis_tlast !== exp_l) begin errors++; $display("FAIL %s_beat%0d tlast got %b want %b", tag, got, m_axis_tlast, exp_l); end
                if (exp_l && exp_fc < FRAMES) exp_fc++;
                got++;
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            held_d = m_axis_tdata; held_l = m_axis_tlast;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_early_done got %b want 0", tag, done); end
            tick();
            cyc++;
            checks++; if (frame_cnt !== FCW'(exp_fc)) begin errors++; $display("FAIL %s_frame_cnt got %0d want %0d", tag, frame_cnt, exp_fc); end
        end
        start = 1'b0; m_axis_tready = 1'b1;
        checks++; if (got != DEPTH) begin errors++; $display("FAIL %s_beat_count got %0d want %0d", tag, got, DEPTH); end
        checks++; if (done !== 1'b1 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            errors++; $display("FAIL %s_end got done=%b busy=%b v=%b want 1 0 0", tag, done, busy, m_axis_tvalid); end
        checks++; if (frame_cnt !== FCW'(FRAMES)) begin errors++; $display("FAIL %s_fc_final got %0d want %0d", tag, frame_cnt, FRAMES); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %b want 0", tag, done); end
    endtask

    task automatic test_loop();
        int exp_fc, k;
        logic exp_l;
        loop = 1'b1; m_axis_tready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        exp_fc = 0;
        for (k = 0; k < 2 * DEPTH + 4; k++) begin
            exp_l = ((k % FRAME_LEN) == FRAME_LEN - 1);
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== mem_m[k % DEPTH] || m_axis_tlast !== exp_l) begin
                errors++; $display("FAIL loop_beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", k, m_axis_tvalid, m_axis_tdata, m_axis_tlast, mem_m[k % DEPTH], exp_l); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL loop_done got %b want 0", done); end
            tick();
            if (exp_l) exp_fc = ((k % DEPTH) + 1) / FRAME_LEN;
            checks++; if (frame_cnt !== FCW'(exp_fc)) begin errors++; $display("FAIL loop_frame_cnt k=%0d got %0d want %0d", k, frame_cnt, exp_fc); end
        end
        loop = 1'b0; m_axis_tready = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0; m_axis_tready = 1'b1;
        checks++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL loop_abort got v=%b busy=%b done=%b want 0 0 0", m_axis_tvalid, busy, done); end
    endtask

    task automatic test_abort();
        int got, n;
        loop = 1'b0; m_axis_tready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        got = 0; n = 0;
        while (got < 6 && n < 40) begin
            if (m_axis_tvalid === 1'b1) begin
                checks++; if (m_axis_tdata !== mem_m[got]) begin errors++; $display("FAIL abort_beat%0d got %h want %h", got, m_axis_tdata, mem_m[got]); end
                got++;
            end
            tick();
            n++;
        end
        checks++; if (got != 6) begin errors++; $display("FAIL abort_beats got %0d want 6", got); end
        m_axis_tready = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || m_axis_tlast !== 1'b0) begin
            errors++; $display("FAIL abort_flush got v=%b busy=%b done=%b l=%b want 0 0 0 0", m_axis_tvalid, busy, done, m_axis_tlast); end
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (done !== 1'b0 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL abort_idle got done=%b v=%b want 0 0", done, m_axis_tvalid); end
        end
    endtask

    task automatic test_wr_err();
        int n;
        loop = 1'b0; m_axis_tready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        wr_en = 1'b1; wr_addr = AW'(3); wr_data = ~mem_m[3];
        tick();
        wr_en = 1'b0;
        checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_pulse got %b want 1", wr_err); end
        tick();
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_clear got %b want 0", wr_err); end
        n = 0;
        while (done !== 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wr_err_done got %b want 1", done); end
        tick();
    endtask

    task automatic test_write_start();
        logic [WIDTH-1:0] v;
        int n;
        v = mem_m[0] ^ (WIDTH'($urandom) | WIDTH'(1));
        mem_m[0] = v;
        loop = 1'b0; m_axis_tready = 1'b1;
        wr_en = 1'b1; wr_addr = AW'(0); wr_data = v; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL ws_wr_err got %b want 0", wr_err); end
        tick(); tick();
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== v) begin
            errors++; $display("FAIL ws_first got v=%b d=%h want v=1 d=%h", m_axis_tvalid, m_axis_tdata, v); end
        n = 0;
        while (done !== 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ws_done got %b want 1", done); end
        tick();
    endtask

    task automatic test_reset_mid();
        loop = 1'b0; m_axis_tready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0) begin
            errors++; $display("FAIL rstmid_bus got v=%b l=%b d=%h want 0 0 0", m_axis_tvalid, m_axis_tlast, m_axis_tdata); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || wr_err !== 1'b0 || frame_cnt !== '0) begin
            errors++; $display("FAIL rstmid_status got busy=%b done=%b wr_err=%b fc=%0d want 0 0 0 0", busy, done, wr_err, frame_cnt); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        load_mem(1'b1);
        test_replay("stream", 0);
        test_replay("backpressure", 1);
        load_mem(1'b0);
        test_replay("random_ready", 2);
        test_loop();
        test_abort();
        test_replay("after_abort", 0);
        test_wr_err();
        test_replay("after_wr_err", 2);
        test_write_start();
        test_reset_mid();
        test_replay("after_reset", 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
